// File: rtl/one_wire_cmd_arbiter.sv
// Round-robin arbiter sharing the 1-wire command FIFO between two requesters.
// A granted requester streams one whole frame (12 + L bytes) into the FIFO.
// The grant is then held until the 1-wire side reports txn_done or a timeout expires.
module one_wire_cmd_arbiter #(
    parameter int unsigned FIFO_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned TMO_WIDTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req,
    input  logic [2*FIFO_WIDTH-1:0] req_data,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    output logic [1:0]              grant,
    input  logic                    fifo_full,
    output logic                    fifo_write_enable,
    output logic [FIFO_WIDTH-1:0]   fifo_write_data,
    input  logic                    txn_done,
    output logic                    busy,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {StIdle, StHeader, StBody, StWaitDone} state_e;

    localparam logic [TMO_WIDTH-1:0] TmoLast = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic                 last_q, last_d;
    logic [6:0]           remaining_q, remaining_d;
    logic [TMO_WIDTH-1:0] tmo_q, tmo_d;
    logic                 timeout_err_q, timeout_err_d;

    logic                 xfer_phase;
    logic                 transfer;
    logic [5:0]           hdr_len;

    // Datapath: the granted requester's byte goes straight through to the FIFO.
    always_comb begin
        xfer_phase        = (state_q == StHeader) || (state_q == StBody);
        req_ready         = (xfer_phase && !fifo_full) ? grant_q : 2'b00;
        transfer          = |(req_ready & req_valid);
        fifo_write_enable = transfer;
        fifo_write_data   = grant_q[1] ? req_data[2*FIFO_WIDTH-1:FIFO_WIDTH]
                                       : req_data[FIFO_WIDTH-1:0];
        hdr_len           = fifo_write_data[7:2];
        grant             = grant_q;
        busy              = (state_q != StIdle);
        timeout_err       = timeout_err_q;
    end

    // Next-state: arbitration, frame byte counting and the WAIT_DONE timeout.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        remaining_d   = remaining_q;
        tmo_d         = tmo_q;
        timeout_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                case (req)
                    2'b01: begin
                        grant_d = 2'b01;
                        last_d  = 1'b0;
                        state_d = StHeader;
                    end
                    2'b10: begin
                        grant_d = 2'b10;
                        last_d  = 1'b1;
                        state_d = StHeader;
                    end
                    2'b11: begin
                        // Tie goes to whoever was not served last.
                        grant_d = last_q ? 2'b01 : 2'b10;
                        last_d  = !last_q;
                        state_d = StHeader;
                    end
                    default: ;
                endcase
            end
            StHeader: begin
                if (transfer) begin
                    // Header byte counted; 11 fixed bytes plus L payload remain.
                    remaining_d = 7'd11 + {1'b0, hdr_len};
                    state_d     = StBody;
                end
            end
            StBody: begin
                if (transfer) begin
                    remaining_d = remaining_q - 7'd1;
                    if (remaining_q == 7'd1) begin
                        tmo_d   = '0;
                        state_d = StWaitDone;
                    end
                end
            end
            StWaitDone: begin
                // Done wins over a simultaneous timeout.
                if (txn_done) begin
                    grant_d = 2'b00;
                    state_d = StIdle;
                end else if (tmo_q == TmoLast) begin
                    timeout_err_d = 1'b1;
                    grant_d       = 2'b00;
                    state_d       = StIdle;
                end else begin
                    tmo_d = tmo_q + TMO_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            grant_q       <= 2'b00;
            last_q        <= 1'b1;
            remaining_q   <= '0;
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            remaining_q   <= remaining_d;
            tmo_q         <= tmo_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_one_wire_cmd_arbiter.sv
// Directed bench for one_wire_cmd_arbiter with a short timeout.
module tb_one_wire_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [15:0] req_data = '0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic        fifo_full = 1'b0;
    logic        fifo_write_enable;
    logic [7:0]  fifo_write_data;
    logic        txn_done = 1'b0;
    logic        busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] wr_q[$];
    int         wcyc_q[$];

    one_wire_cmd_arbiter #(
        .FIFO_WIDTH     (8),
        .TIMEOUT_CYCLES (20),
        .TMO_WIDTH      (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req               (req),
        .req_data          (req_data),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .grant             (grant),
        .fifo_full         (fifo_full),
        .fifo_write_enable (fifo_write_enable),
        .fifo_write_data   (fifo_write_data),
        .txn_done          (txn_done),
        .busy              (busy),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: capture every byte the DUT commits on the coming edge.
    always @(negedge clk) begin
        if (!rst && fifo_write_enable) begin
            wr_q.push_back(fifo_write_data);
            wcyc_q.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] frame_byte(input int r, input int idx, input logic [7:0] hdr);
        logic [7:0] b;
        if (idx == 0) b = hdr;
        else b = 8'((idx * 7) + (r * 64) + 1);
        return b;
    endfunction

    // Present one byte from requester r and hold it until it transfers.
    task automatic drive_byte(input int r, input logic [7:0] b);
        int n;
        n = 0;
        req_valid[r] = 1'b1;
        req_data[8*r +: 8] = b;
        @(negedge clk);
        while (!req_ready[r] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("ready_bound", 0, 1);
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
    endtask

    // Stream a full frame; optional txn_done pulse and fifo_full stall at given byte.
    task automatic send_frame(input int r, input logic [7:0] hdr, input int done_at,
                              input int stall_at, input int stall_len);
        int n;
        n = 12 + int'(hdr[7:2]);
        wr_q.delete();
        wcyc_q.delete();
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                req_valid[r] = 1'b1;
                req_data[8*r +: 8] = frame_byte(r, i, hdr);
                fifo_full = 1'b1;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    check_eq("stall_ready", 32'(req_ready), 0);
                    check_eq("stall_we", 32'(fifo_write_enable), 0);
                    @(posedge clk);
                    #1;
                end
                fifo_full = 1'b0;
            end
            if (i == done_at) txn_done = 1'b1;
            drive_byte(r, frame_byte(r, i, hdr));
            txn_done = 1'b0;
        end
    endtask

    task automatic verify_frame(input int r, input logic [7:0] hdr, input int stall_len);
        int n;
        n = 12 + int'(hdr[7:2]);
        check_eq("wr_count", 32'(wr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_q.size(); i++)
            check_eq($sformatf("wr_byte%0d", i), 32'(wr_q[i]), 32'(frame_byte(r, i, hdr)));
        if (wcyc_q.size() == n)
            check_eq("wr_span", 32'(wcyc_q[n-1] - wcyc_q[0]), 32'(n - 1 + stall_len));
    endtask

    task automatic pulse_done();
        txn_done = 1'b1;
        @(posedge clk);
        #1;
        txn_done = 1'b0;
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_grant", 32'(grant), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_tmo", 32'(timeout_err), 0);
        check_eq("rst_ready", 32'(req_ready), 0);
        check_eq("rst_we", 32'(fifo_write_enable), 0);

        // Single requester, header 0x0C -> 15 bytes back to back.
        @(posedge clk);
        #1;
        req = 2'b01;
        @(negedge clk);
        check_eq("t1_grant_late", 32'(grant), 0);
        @(posedge clk);
        #1;
        check_eq("t1_grant", 32'(grant), 32'h1);
        req = 2'b00;
        send_frame(0, 8'h0C, -1, -1, 0);
        verify_frame(0, 8'h0C, 0);
        @(negedge clk);
        check_eq("t1_wait_grant", 32'(grant), 32'h1);
        check_eq("t1_wait_busy", 32'(busy), 1);
        check_eq("t1_wait_ready", 32'(req_ready), 0);
        pulse_done();
        check_eq("t1_end_grant", 32'(grant), 0);
        check_eq("t1_end_busy", 32'(busy), 0);

        // Fresh reset, both request together: requester 0 first.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 2'b11;
        @(posedge clk);
        #1;
        check_eq("rr_first", 32'(grant), 32'h1);
        req = 2'b10;
        // txn_done during BODY must be ignored.
        send_frame(0, 8'h00, 5, -1, 0);
        verify_frame(0, 8'h00, 0);
        check_eq("body_done_grant", 32'(grant), 32'h1);
        check_eq("body_done_busy", 32'(busy), 1);
        // Done on the timeout-threshold cycle counts as done.
        repeat (19) @(posedge clk);
        #1;
        txn_done = 1'b1;
        @(posedge clk);
        #1;
        txn_done = 1'b0;
        check_eq("thr_tmo", 32'(timeout_err), 0);
        check_eq("thr_grant", 32'(grant), 0);
        @(negedge clk);
        check_eq("dead_cycle", 32'(grant), 0);
        @(posedge clk);
        #1;
        check_eq("rr_second", 32'(grant), 32'h2);
        req = 2'b00;
        send_frame(1, 8'h04, -1, -1, 0);
        verify_frame(1, 8'h04, 0);
        pulse_done();
        req = 2'b11;
        @(posedge clk);
        #1;
        check_eq("rr_third", 32'(grant), 32'h1);
        req = 2'b00;

        // fifo_full stall of 5 cycles on byte 6, L=5.
        send_frame(0, 8'h14, -1, 6, 5);
        verify_frame(0, 8'h14, 5);

        // Withheld txn_done: timeout 20 cycles after entering WAIT_DONE.
        k = 0;
        @(negedge clk);
        while (!timeout_err && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq("tmo_delay", 32'(k), 20);
        check_eq("tmo_grant", 32'(grant), 0);
        @(negedge clk);
        check_eq("tmo_pulse_once", 32'(timeout_err), 0);

        // Reset mid-frame after 4 bytes.
        @(posedge clk);
        #1;
        req = 2'b01;
        @(posedge clk);
        #1;
        req = 2'b00;
        for (int i = 0; i < 4; i++) drive_byte(0, frame_byte(0, i, 8'h08));
        req_valid[0] = 1'b1;
        req_data[7:0] = frame_byte(0, 4, 8'h08);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_grant", 32'(grant), 0);
        check_eq("ar_ready", 32'(req_ready), 0);
        check_eq("ar_we", 32'(fifo_write_enable), 0);
        check_eq("ar_busy", 32'(busy), 0);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 2'b10;
        @(posedge clk);
        #1;
        check_eq("ar_new_grant", 32'(grant), 32'h2);
        req = 2'b00;
        send_frame(1, 8'h08, -1, -1, 0);
        verify_frame(1, 8'h08, 0);
        pulse_done();
        check_eq("ar_end_grant", 32'(grant), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
